count_mod: RTL and testbench
============================

COUNT_MOD -- requirements
Module: count_mod

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning the count register width in bits (legal range 2..64).
REQ-002 SHALL have parameter PRESCALE, default 1, meaning the number of enabled cycles per count step (legal range 1..65535).
REQ-003 SHALL have parameter SAT_MODE, default 0: 0 = wrap at boundaries, 1 = saturate at boundaries.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-006 SHALL have port en, input, 1 bit: count enable; it qualifies the prescaler.
REQ-007 SHALL have port up_dn, input, 1 bit: direction, 1 = up, 0 = down.
REQ-008 SHALL have port clr, input, 1 bit: synchronous clear.
REQ-009 SHALL have port load, input, 1 bit: synchronous load strobe.
REQ-010 SHALL have port load_val, input, WIDTH bits: value to load.
REQ-011 SHALL have port modulus, input, WIDTH bits: upper bound; the count range is 0..modulus inclusive.
REQ-012 SHALL have port count, output, WIDTH bits: registered count value.
REQ-013 SHALL have port tc, output, 1 bit: registered one-cycle terminal-count pulse.
REQ-014 SHALL have port ovf, output, 1 bit: sticky boundary-event flag.

Function
REQ-015 Priority SHALL be clr > load > step, evaluated each cycle.
REQ-016 clr SHALL set count to 0, prescaler to 0, tc to 0 and ovf to 0 on the next edge.
REQ-017 load SHALL set count to min(load_val, modulus) and the prescaler to 0; tc SHALL be 0 that cycle.
REQ-018 Prescaler SHALL increment on each cycle with en=1, and SHALL produce a step and return to 0 when it equals PRESCALE-1; en=0 SHALL freeze the prescaler and count.
REQ-019 With PRESCALE=1, every en=1 cycle SHALL be a step, so count updates one cycle after en is sampled.
REQ-020 Up step SHALL produce count+1 when count < modulus; at count >= modulus it SHALL produce 0 (SAT_MODE=0) or modulus (SAT_MODE=1).
REQ-021 Down step SHALL produce count-1 when 0 < count <= modulus; at count=0 it SHALL produce modulus (SAT_MODE=0) or 0 (SAT_MODE=1).
REQ-022 Down step with count > modulus (modulus lowered mid-run) SHALL produce modulus.
REQ-023 A step taken from a boundary (REQ-020/021 wrap or saturate branch) SHALL assert tc for exactly the following cycle and SHALL set ovf.
REQ-024 In SAT_MODE=1, repeated steps at the boundary SHALL pulse tc on every such step.
REQ-025 modulus=0 SHALL hold count at 0, with every step treated as a boundary event.
REQ-026 Arithmetic SHALL be WIDTH-bit unsigned and never wider; no internal carry SHALL be visible.
REQ-027 up_dn and modulus SHALL be sampled only on step cycles; changes between steps SHALL have no effect.

Reset
REQ-028 While rst_n=0, count, tc, ovf and the prescaler SHALL be 0, regardless of clk.
REQ-029 Reset deassertion SHALL take effect at the first rising clk edge after deassertion; the first step SHALL occur only after a full PRESCALE enabled cycles.
REQ-030 Reset asserted mid-operation SHALL abort any pending tc pulse.

Structure
REQ-031 Shared package count_pkg SHALL hold the SAT_MODE encodings (MODE_WRAP=0, MODE_SAT=1).
REQ-032 Prescaler SHALL be a sub-module, count_prescale (inputs clk, rst_n, en, sync_clr; output step), which SHALL be bypassed to step=en when PRESCALE=1.
REQ-033 Top-level outputs SHALL be driven directly from registers.

Verification
REQ-034 WIDTH=8, PRESCALE=1, modulus=9, up, en=1 for 12 cycles from reset -> count 1..9,0,1,2; tc high the cycle count shows 0; ovf=1 thereafter.
REQ-035 Same configuration, down from count 0 -> next count=9, with a tc pulse; SAT_MODE=1 -> count stays 0 and tc pulses on each step.
REQ-036 PRESCALE=4, en=1 continuous -> count increments every 4th cycle; en low for 2 cycles mid-period -> step delayed by exactly 2 cycles.
REQ-037 load=1, load_val=200, modulus=50 -> count=50; load and clr asserted together -> count=0 and ovf=0.
REQ-038 count=30, modulus changed to 10, up step -> count=0 with a tc pulse; down step -> count=10 with no tc pulse.
REQ-039 rst_n pulled low asynchronously mid-count at 0x0000_1234 (WIDTH=32) -> count=0 before the next clk edge; no tc pulse after release.

Source files
------------

// File: rtl/count_pkg.sv
// count_pkg: shared encodings for the count_mod counter slice
package count_pkg;
   localparam int MODE_WRAP = 0;
   localparam int MODE_SAT  = 1;
   typedef enum logic {DIR_DN = 1'b0, DIR_UP = 1'b1} dir_e;
endpackage

// File: rtl/count_mod_if.sv
// count_mod_if: control and status bundle of the count_mod counter
interface count_mod_if #(parameter int WIDTH = 32);
   logic             en;
   logic             up_dn;
   logic             clr;
   logic             load;
   logic [WIDTH-1:0] load_val;
   logic [WIDTH-1:0] modulus;
   logic [WIDTH-1:0] count;
   logic             tc;
   logic             ovf;
   modport master (output en, up_dn, clr, load, load_val, modulus, input count, tc, ovf);
   modport slave (input en, up_dn, clr, load, load_val, modulus, output count, tc, ovf);
endinterface

// File: rtl/count_prescale.sv
// count_prescale: turns every PRESCALE enabled cycles into one step strobe
module count_prescale #(
   parameter int PRESCALE = 1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   input  logic sync_clr,
   output logic step
);
   generate
      if (PRESCALE == 1) begin : g_bypass
         logic unused_in;
         assign unused_in = ^{clk, rst_n, sync_clr};
         assign step = en;
      end else begin : g_div
         localparam int CW = $clog2(PRESCALE);
         logic [CW-1:0] cnt;
         assign step = en && cnt == CW'(PRESCALE - 1);
         always_ff @(posedge clk or negedge rst_n)
            if (!rst_n) cnt <= '0;
            else if (sync_clr) cnt <= '0;
            else if (en) cnt <= step ? '0 : cnt + CW'(1);
      end
   endgenerate
endmodule

// File: rtl/count_mod.sv
// count_mod: prescaled up/down modulus counter with wrap or saturate boundaries
module count_mod
   import count_pkg::*;
#(
   parameter int WIDTH    = 32,
   parameter int PRESCALE = 1,
   parameter int SAT_MODE = MODE_WRAP
) (
   input logic        clk,
   input logic        rst_n,
   count_mod_if.slave bus
);
   localparam bit SAT = SAT_MODE == MODE_SAT;
   logic             step;
   logic             at_bnd;
   dir_e             dir;
   logic [WIDTH-1:0] nxt;
   logic [WIDTH-1:0] clamp;
   count_prescale #(.PRESCALE(PRESCALE)) u_pre (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (bus.en),
      .sync_clr (bus.clr | bus.load),
      .step     (step)
   );
   assign dir = dir_e'(bus.up_dn);
   // count above a lowered modulus falls back to modulus on a down step, not a boundary event
   always_comb begin
      at_bnd = dir == DIR_UP ? bus.count >= bus.modulus : bus.count == '0;
      nxt    = dir == DIR_UP
             ? (at_bnd ? (SAT ? bus.modulus : '0) : bus.count + WIDTH'(1))
             : (at_bnd ? (SAT ? '0 : bus.modulus)
                       : (bus.count > bus.modulus ? bus.modulus : bus.count - WIDTH'(1)));
      clamp  = bus.load_val > bus.modulus ? bus.modulus : bus.load_val;
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         bus.count <= '0;
         bus.tc    <= 1'b0;
         bus.ovf   <= 1'b0;
      end else if (bus.clr) begin
         bus.count <= '0;
         bus.tc    <= 1'b0;
         bus.ovf   <= 1'b0;
      end else if (bus.load) begin
         bus.count <= clamp;
         bus.tc    <= 1'b0;
      end else if (step) begin
         bus.count <= nxt;
         bus.tc    <= at_bnd;
         bus.ovf   <= bus.ovf | at_bnd;
      end else begin
         bus.tc    <= 1'b0;
      end
endmodule

// File: tb/tb_count_mod.sv
// tb_count_mod: directed checks of count_mod across wrap, saturate, prescale and 32-bit builds
module tb_count_mod;
   import count_pkg::*;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   failures = 0;
   always #5 clk = ~clk;
   count_mod_if #(.WIDTH(8))  bw ();
   count_mod_if #(.WIDTH(8))  bs ();
   count_mod_if #(.WIDTH(8))  bp ();
   count_mod_if #(.WIDTH(32)) bl ();
   count_mod #(.WIDTH(8),  .PRESCALE(1), .SAT_MODE(MODE_WRAP)) u_w (.clk(clk), .rst_n(rst_n), .bus(bw));
   count_mod #(.WIDTH(8),  .PRESCALE(1), .SAT_MODE(MODE_SAT))  u_s (.clk(clk), .rst_n(rst_n), .bus(bs));
   count_mod #(.WIDTH(8),  .PRESCALE(4), .SAT_MODE(MODE_WRAP)) u_p (.clk(clk), .rst_n(rst_n), .bus(bp));
   count_mod #(.WIDTH(32), .PRESCALE(1), .SAT_MODE(MODE_WRAP)) u_l (.clk(clk), .rst_n(rst_n), .bus(bl));
   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   initial begin
      {bw.en, bw.up_dn, bw.clr, bw.load, bw.load_val, bw.modulus} = '0;
      {bs.en, bs.up_dn, bs.clr, bs.load, bs.load_val, bs.modulus} = '0;
      {bp.en, bp.up_dn, bp.clr, bp.load, bp.load_val, bp.modulus} = '0;
      {bl.en, bl.up_dn, bl.clr, bl.load, bl.load_val, bl.modulus} = '0;
      tick();
      tick();
      chk("rst_w_count", 64'(bw.count), 0);
      chk("rst_w_tc", 64'(bw.tc), 0);
      chk("rst_w_ovf", 64'(bw.ovf), 0);
      chk("rst_p_count", 64'(bp.count), 0);
      chk("rst_l_count", 64'(bl.count), 0);
      rst_n = 1'b1;
      // wrap up-count through modulus 9
      bw.modulus = 8'd9; bw.up_dn = 1'b1; bw.en = 1'b1;
      for (int i = 1; i <= 12; i++) begin
         tick();
         chk($sformatf("up_count_%0d", i), 64'(bw.count), 64'(i % 10));
         chk($sformatf("up_tc_%0d", i), 64'(bw.tc), 64'(i == 10));
         chk($sformatf("up_ovf_%0d", i), 64'(bw.ovf), 64'(i >= 10));
      end
      bw.en = 1'b0;
      bw.clr = 1'b1;
      tick();
      chk("clr_count", 64'(bw.count), 0);
      chk("clr_ovf", 64'(bw.ovf), 0);
      bw.clr = 1'b0; bw.up_dn = 1'b0; bw.en = 1'b1;
      tick();
      chk("dn_wrap_count", 64'(bw.count), 9);
      chk("dn_wrap_tc", 64'(bw.tc), 1);
      chk("dn_wrap_ovf", 64'(bw.ovf), 1);
      bw.en = 1'b0;
      tick();
      chk("tc_one_cycle", 64'(bw.tc), 0);
      chk("hold_count", 64'(bw.count), 9);
      // saturate: repeated boundary steps pulse tc every time
      bs.modulus = 8'd9; bs.up_dn = 1'b0; bs.en = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk($sformatf("sat_dn_count_%0d", i), 64'(bs.count), 0);
         chk($sformatf("sat_dn_tc_%0d", i), 64'(bs.tc), 1);
      end
      bs.en = 1'b0; bs.load = 1'b1; bs.load_val = 8'd9;
      tick();
      chk("sat_load_tc", 64'(bs.tc), 0);
      bs.load = 1'b0; bs.up_dn = 1'b1; bs.en = 1'b1;
      for (int i = 0; i < 2; i++) begin
         tick();
         chk($sformatf("sat_up_count_%0d", i), 64'(bs.count), 9);
         chk($sformatf("sat_up_tc_%0d", i), 64'(bs.tc), 1);
      end
      bs.en = 1'b0;
      // prescale by 4, then a 2-cycle enable gap mid-period
      bp.modulus = 8'd50; bp.up_dn = 1'b1; bp.en = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         tick();
         chk($sformatf("pre_count_%0d", i), 64'(bp.count), 64'(i / 4));
      end
      tick();
      bp.en = 1'b0;
      tick();
      tick();
      bp.en = 1'b1;
      tick();
      tick();
      chk("pre_gap_before", 64'(bp.count), 2);
      tick();
      chk("pre_gap_step", 64'(bp.count), 3);
      chk("pre_gap_tc", 64'(bp.tc), 0);
      bp.en = 1'b0;
      // load clamps to modulus; clr beats load
      bw.modulus = 8'd50; bw.load = 1'b1; bw.load_val = 8'd200;
      tick();
      chk("load_clamp", 64'(bw.count), 50);
      chk("load_tc", 64'(bw.tc), 0);
      chk("load_keeps_ovf", 64'(bw.ovf), 1);
      bw.clr = 1'b1;
      tick();
      chk("clr_load_count", 64'(bw.count), 0);
      chk("clr_load_ovf", 64'(bw.ovf), 0);
      bw.clr = 1'b0; bw.load_val = 8'd30;
      tick();
      chk("load_30", 64'(bw.count), 30);
      bw.load = 1'b0; bw.modulus = 8'd10;
      tick();
      chk("no_step_mod_change", 64'(bw.count), 30);
      bw.up_dn = 1'b1; bw.en = 1'b1;
      tick();
      chk("lowmod_up_count", 64'(bw.count), 0);
      chk("lowmod_up_tc", 64'(bw.tc), 1);
      bw.en = 1'b0; bw.modulus = 8'd50; bw.load = 1'b1;
      tick();
      bw.load = 1'b0; bw.modulus = 8'd10; bw.up_dn = 1'b0; bw.en = 1'b1;
      tick();
      chk("lowmod_dn_count", 64'(bw.count), 10);
      chk("lowmod_dn_tc", 64'(bw.tc), 0);
      bw.modulus = 8'd0; bw.up_dn = 1'b1;
      tick();
      chk("mod0_count", 64'(bw.count), 0);
      chk("mod0_tc", 64'(bw.tc), 1);
      bw.en = 1'b0;
      // asynchronous reset with a boundary step about to happen
      bl.modulus = 32'h0000_1234; bl.load_val = 32'h0000_1234; bl.load = 1'b1;
      tick();
      chk("l_load", 64'(bl.count), 64'h1234);
      bl.load = 1'b0; bl.up_dn = 1'b1; bl.en = 1'b1;
      #3;
      rst_n = 1'b0;
      #1;
      chk("async_rst_count", 64'(bl.count), 0);
      chk("async_rst_tc", 64'(bl.tc), 0);
      tick();
      chk("rst_held_count", 64'(bl.count), 0);
      chk("rst_held_tc", 64'(bl.tc), 0);
      rst_n = 1'b1;
      tick();
      chk("post_rst_count", 64'(bl.count), 1);
      chk("post_rst_tc", 64'(bl.tc), 0);
      tick();
      chk("post_rst_tc2", 64'(bl.tc), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
